// File: rtl/arch_dbg_pkg.sv
// Shared types and constants for the architectural-state dumper.
package arch_dbg_pkg;

    // Stream word type carried on out_tag_o
    typedef enum logic [1:0] {
        TAG_PC  = 2'd0,
        TAG_REG = 2'd1,
        TAG_MEM = 2'd2,
        TAG_END = 2'd3
    } tag_t;

    // Dump sequencer states
    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_EMIT_PC  = 3'd1,
        ST_REG_RD   = 3'd2,
        ST_REG_OUT  = 3'd3,
        ST_MEM_RD   = 3'd4,
        ST_MEM_OUT  = 3'd5,
        ST_EMIT_END = 3'd6
    } state_t;

    // Trigger filtering modes
    localparam int MODE_ALL       = 0;
    localparam int MODE_PC_CHANGE = 1;

endpackage

// File: rtl/arch_state_dumper_dump_out_reg.sv
// Output holding register: one tagged word with valid/ready hold behaviour.
module dump_out_reg
    import arch_dbg_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_load,
    input  tag_t              i_tag,
    input  logic [7:0]        i_idx,
    input  logic [DATA_W-1:0] i_data,
    input  logic              i_ready,
    output logic              o_valid,
    output tag_t              o_tag,
    output logic [7:0]        o_idx,
    output logic [DATA_W-1:0] o_data,
    output logic              o_fire
);

    logic              r_valid;
    tag_t              r_tag;
    logic [7:0]        r_idx;
    logic [DATA_W-1:0] r_data;

    // Load a new word (takes priority), otherwise drop valid after a handshake
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_valid <= 1'b0;
            r_tag   <= TAG_PC;
            r_idx   <= '0;
            r_data  <= '0;
        end else if (i_load) begin
            r_valid <= 1'b1;
            r_tag   <= i_tag;
            r_idx   <= i_idx;
            r_data  <= i_data;
        end else if (r_valid && i_ready) begin
            r_valid <= 1'b0;
        end
    end

    assign o_valid = r_valid;
    assign o_tag   = r_tag;
    assign o_idx   = r_idx;
    assign o_data  = r_data;
    assign o_fire  = r_valid & i_ready;

endmodule

// File: rtl/arch_state_dumper.sv
// Architectural-state tracer: on retire, streams PC, a register window and a
// memory window as tagged words over valid/ready.
module arch_state_dumper
    import arch_dbg_pkg::*;
#(
    parameter int DATA_W    = 32,
    parameter int NUM_REGS  = 32,
    parameter int MEM_AW    = 8,
    parameter int MEM_BASE  = 0,
    parameter int MEM_WORDS = 32,
    parameter int MODE      = MODE_ALL
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              trig_i,
    input  logic [DATA_W-1:0] pc_i,
    output logic [4:0]        dbg_reg_addr_o,
    input  logic [DATA_W-1:0] dbg_reg_data_i,
    output logic [MEM_AW-1:0] dbg_mem_addr_o,
    input  logic [DATA_W-1:0] dbg_mem_data_i,
    output logic              out_valid_o,
    input  logic              out_ready_i,
    output logic [1:0]        out_tag_o,
    output logic [7:0]        out_idx_o,
    output logic [DATA_W-1:0] out_data_o,
    output logic              busy_o,
    output logic [15:0]       drop_cnt_o
);

    localparam logic [7:0]        REG_LAST   = 8'(NUM_REGS - 1);
    localparam logic [7:0]        MEM_LAST   = 8'(MEM_WORDS - 1);
    localparam logic [MEM_AW-1:0] MEM_BASE_A = MEM_AW'(MEM_BASE);

    state_t              r_state, w_next;
    logic [7:0]          r_idx, w_idx_next;
    logic                w_idx_ld, w_reg_addr_ld, w_mem_addr_ld, w_pc_done, w_accept;
    logic                w_load;
    tag_t                w_ld_tag;
    logic [7:0]          w_ld_idx;
    logic [DATA_W-1:0]   w_ld_data;
    logic                w_fire, w_out_valid;
    tag_t                w_out_tag;
    logic [7:0]          w_out_idx;
    logic [DATA_W-1:0]   w_out_data;
    logic [DATA_W-1:0]   r_last_pc;
    logic                r_last_pc_valid;
    logic [4:0]          r_reg_addr;
    logic [MEM_AW-1:0]   r_mem_addr;
    logic [15:0]         r_drop_cnt;

    // State register
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) r_state <= ST_IDLE;
        else        r_state <= w_next;
    end

    // Next state and output-word load control. Each debug read address is
    // registered on the edge entering its RD state; the read data is captured
    // into the output register at the end of that RD cycle, so the word is
    // valid during the following OUT cycle.
    always_comb begin
        w_next        = r_state;
        w_load        = 1'b0;
        w_ld_tag      = TAG_PC;
        w_ld_idx      = '0;
        w_ld_data     = '0;
        w_idx_ld      = 1'b0;
        w_idx_next    = r_idx;
        w_reg_addr_ld = 1'b0;
        w_mem_addr_ld = 1'b0;
        w_pc_done     = 1'b0;
        w_accept      = (MODE != MODE_PC_CHANGE) || !r_last_pc_valid || (pc_i != r_last_pc);
        unique case (r_state)
            ST_IDLE: if (trig_i && w_accept) begin
                w_next    = ST_EMIT_PC;
                w_load    = 1'b1;
                w_ld_tag  = TAG_PC;
                w_ld_data = pc_i;
            end
            ST_EMIT_PC: if (w_fire) begin
                w_next        = ST_REG_RD;
                w_pc_done     = 1'b1;
                w_idx_ld      = 1'b1;
                w_idx_next    = '0;
                w_reg_addr_ld = 1'b1;
            end
            ST_REG_RD: begin
                w_next    = ST_REG_OUT;
                w_load    = 1'b1;
                w_ld_tag  = TAG_REG;
                w_ld_idx  = r_idx;
                w_ld_data = dbg_reg_data_i;
            end
            ST_REG_OUT: if (w_fire) begin
                w_idx_ld = 1'b1;
                if (r_idx == REG_LAST) begin
                    w_idx_next = '0;
                    if (MEM_WORDS == 0) begin
                        w_next   = ST_EMIT_END;
                        w_load   = 1'b1;
                        w_ld_tag = TAG_END;
                    end else begin
                        w_next        = ST_MEM_RD;
                        w_mem_addr_ld = 1'b1;
                    end
                end else begin
                    w_idx_next    = r_idx + 8'd1;
                    w_reg_addr_ld = 1'b1;
                    w_next        = ST_REG_RD;
                end
            end
            ST_MEM_RD: begin
                w_next    = ST_MEM_OUT;
                w_load    = 1'b1;
                w_ld_tag  = TAG_MEM;
                w_ld_idx  = r_idx;
                w_ld_data = dbg_mem_data_i;
            end
            ST_MEM_OUT: if (w_fire) begin
                if (r_idx == MEM_LAST) begin
                    w_next   = ST_EMIT_END;
                    w_load   = 1'b1;
                    w_ld_tag = TAG_END;
                end else begin
                    w_idx_ld      = 1'b1;
                    w_idx_next    = r_idx + 8'd1;
                    w_mem_addr_ld = 1'b1;
                    w_next        = ST_MEM_RD;
                end
            end
            ST_EMIT_END: if (w_fire) w_next = ST_IDLE;
            default: w_next = ST_IDLE;
        endcase
    end

    // Index, debug addresses, last-dumped PC and saturating drop counter
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_idx           <= '0;
            r_reg_addr      <= '0;
            r_mem_addr      <= '0;
            r_last_pc       <= '0;
            r_last_pc_valid <= 1'b0;
            r_drop_cnt      <= '0;
        end else begin
            if (w_idx_ld)      r_idx      <= w_idx_next;
            if (w_reg_addr_ld) r_reg_addr <= w_idx_next[4:0];
            if (w_mem_addr_ld) r_mem_addr <= MEM_BASE_A + MEM_AW'(w_idx_next);
            if (w_pc_done) begin
                r_last_pc       <= w_out_data;
                r_last_pc_valid <= 1'b1;
            end
            if (trig_i && (r_state != ST_IDLE) && (r_drop_cnt != 16'hFFFF))
                r_drop_cnt <= r_drop_cnt + 16'd1;
        end
    end

    dump_out_reg #(.DATA_W(DATA_W)) u_out (
        .i_clk   (clk_i),
        .i_rst_n (rst_i),
        .i_load  (w_load),
        .i_tag   (w_ld_tag),
        .i_idx   (w_ld_idx),
        .i_data  (w_ld_data),
        .i_ready (out_ready_i),
        .o_valid (w_out_valid),
        .o_tag   (w_out_tag),
        .o_idx   (w_out_idx),
        .o_data  (w_out_data),
        .o_fire  (w_fire)
    );

    assign out_valid_o    = w_out_valid;
    assign out_tag_o      = w_out_tag;
    assign out_idx_o      = w_out_idx;
    assign out_data_o     = w_out_data;
    assign dbg_reg_addr_o = r_reg_addr;
    assign dbg_mem_addr_o = r_mem_addr;
    assign busy_o         = (r_state != ST_IDLE);
    assign drop_cnt_o     = r_drop_cnt;

endmodule

// File: tb/tb_arch_state_dumper.sv
// Bench for arch_state_dumper: three configurations, scoreboard of expected words.
module tb_arch_state_dumper;

    typedef struct packed {
        logic [1:0]  dut;
        logic [1:0]  tag;
        logic [7:0]  idx;
        logic [31:0] data;
    } word_t;

    logic clk = 1'b0;
    logic rst_n;
    logic [2:0] trig, rdy;
    logic [31:0] pc [3];

    wire [2:0]       vld, bsy;
    wire [2:0][1:0]  tag;
    wire [2:0][7:0]  idx, maddr;
    wire [2:0][4:0]  raddr;
    wire [2:0][31:0] dat, rdata, mdata;
    wire [2:0][15:0] drop;

    logic [31:0] regs [32];
    logic [31:0] mem  [256];

    word_t q[$];
    word_t hw [3];
    logic  held [3];
    int checks = 0;
    int errors = 0;
    int mk = 0;
    logic [7:0] exp_ma [4];

    always #5 clk = ~clk;

    for (genvar d = 0; d < 3; d++) begin : g_mem
        assign rdata[d] = regs[raddr[d]];
        assign mdata[d] = mem[maddr[d]];
    end

    arch_state_dumper #(.NUM_REGS(4), .MEM_WORDS(2)) dut0 (
        .clk_i(clk), .rst_i(rst_n), .trig_i(trig[0]), .pc_i(pc[0]),
        .dbg_reg_addr_o(raddr[0]), .dbg_reg_data_i(rdata[0]),
        .dbg_mem_addr_o(maddr[0]), .dbg_mem_data_i(mdata[0]),
        .out_valid_o(vld[0]), .out_ready_i(rdy[0]), .out_tag_o(tag[0]),
        .out_idx_o(idx[0]), .out_data_o(dat[0]), .busy_o(bsy[0]), .drop_cnt_o(drop[0])
    );

    arch_state_dumper #(.NUM_REGS(4), .MEM_WORDS(2), .MODE(1)) dut1 (
        .clk_i(clk), .rst_i(rst_n), .trig_i(trig[1]), .pc_i(pc[1]),
        .dbg_reg_addr_o(raddr[1]), .dbg_reg_data_i(rdata[1]),
        .dbg_mem_addr_o(maddr[1]), .dbg_mem_data_i(mdata[1]),
        .out_valid_o(vld[1]), .out_ready_i(rdy[1]), .out_tag_o(tag[1]),
        .out_idx_o(idx[1]), .out_data_o(dat[1]), .busy_o(bsy[1]), .drop_cnt_o(drop[1])
    );

    arch_state_dumper #(.NUM_REGS(2), .MEM_BASE(254), .MEM_WORDS(4)) dut2 (
        .clk_i(clk), .rst_i(rst_n), .trig_i(trig[2]), .pc_i(pc[2]),
        .dbg_reg_addr_o(raddr[2]), .dbg_reg_data_i(rdata[2]),
        .dbg_mem_addr_o(maddr[2]), .dbg_mem_data_i(mdata[2]),
        .out_valid_o(vld[2]), .out_ready_i(rdy[2]), .out_tag_o(tag[2]),
        .out_idx_o(idx[2]), .out_data_o(dat[2]), .busy_o(bsy[2]), .drop_cnt_o(drop[2])
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        assert (act === exp) else begin
            errors++;
            $error("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Stream monitor: hold stability while stalled, scoreboard pop on handshake
    task automatic mon(input int d, input logic v, input logic r, input logic [1:0] t,
                       input logic [7:0] ix, input logic [31:0] dv);
        word_t e;
        if (rst_n !== 1'b1) begin
            held[d] = 1'b0;
            return;
        end
        if (held[d]) begin
            checks++;
            assert ({v, t, ix, dv} === {1'b1, hw[d].tag, hw[d].idx, hw[d].data}) else begin
                errors++;
                $error("FAIL hold%0d: got v%0b %0h/%0h/%0h expected %0h/%0h/%0h", d, v, t, ix, dv,
                       hw[d].tag, hw[d].idx, hw[d].data);
            end
        end
        held[d] = v && !r;
        hw[d]   = {2'(d), t, ix, dv};
        if (v && r) begin
            checks++;
            assert ((q.size() > 0) === 1'b1) else begin
                errors++;
                $error("FAIL word%0d: got unexpected %0h/%0h/%0h expected none", d, t, ix, dv);
            end
            if (q.size() > 0) begin
                e = q.pop_front();
                checks++;
                assert ({2'(d), t, ix, dv} === e) else begin
                    errors++;
                    $error("FAIL word%0d: got %0h/%0h/%0h expected dut%0d %0h/%0h/%0h", d, t, ix, dv,
                           e.dut, e.tag, e.idx, e.data);
                end
            end
        end
    endtask

    always @(negedge clk) mon(0, vld[0], rdy[0], tag[0], idx[0], dat[0]);
    always @(negedge clk) mon(1, vld[1], rdy[1], tag[1], idx[1], dat[1]);
    always @(negedge clk) mon(2, vld[2], rdy[2], tag[2], idx[2], dat[2]);

    // Memory debug address seen at each memory-word handshake of the wrapping config
    always @(negedge clk) begin
        if (rst_n === 1'b1 && vld[2] && rdy[2] && tag[2] == 2'd2) begin
            checks++;
            if (mk < 4) begin
                assert (maddr[2] === exp_ma[mk]) else begin
                    errors++;
                    $error("FAIL memaddr: got %0h expected %0h", maddr[2], exp_ma[mk]);
                end
            end else begin
                errors++;
                $error("FAIL memaddr: got extra address %0h expected none", maddr[2]);
            end
            mk++;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_dump(input int d, input logic [31:0] p, input int nr, input int base, input int nm);
        q.push_back({2'(d), 2'd0, 8'd0, p});
        for (int i = 0; i < nr; i++) q.push_back({2'(d), 2'd1, 8'(i), regs[i]});
        for (int i = 0; i < nm; i++) q.push_back({2'(d), 2'd2, 8'(i), mem[(base + i) % 256]});
        q.push_back({2'(d), 2'd3, 8'd0, 32'd0});
    endtask

    task automatic fire(input int d, input logic [31:0] p);
        pc[d]   = p;
        trig[d] = 1'b1;
        tick();
        trig[d] = 1'b0;
    endtask

    // Run until the dump ends; rmode 1 toggles ready 1010..., drop_test adds
    // a trigger on the third busy cycle and on the END handshake cycle.
    task automatic run(input int d, input int rmode, input bit drop_test, output int n);
        n = 0;
        while (bsy[d] && n < 400) begin
            if (rmode == 1) rdy[d] = (n % 2 == 0);
            if (drop_test) trig[d] = (n == 2) || (vld[d] && tag[d] == 2'd3);
            tick();
            n++;
        end
        trig[d] = 1'b0;
        rdy[d]  = 1'b1;
        chk("dump_timeout", 32'(bsy[d]), 32'd0);
    endtask

    initial begin
        int n;
        exp_ma = '{8'hFE, 8'hFF, 8'h00, 8'h01};
        for (int i = 0; i < 3; i++) begin
            held[i] = 1'b0;
            pc[i]   = '0;
        end
        for (int i = 0; i < 32; i++)  regs[i] = 32'hDEAD_0000 + 32'(i);
        for (int i = 0; i < 256; i++) mem[i]  = 32'hBEEF_0000 + 32'(i);
        regs[0] = 32'd0; regs[1] = 32'd5; regs[2] = 32'd7; regs[3] = 32'd9;
        mem[0] = 32'd3;  mem[1] = 32'd4;
        trig  = '0;
        rdy   = 3'b111;
        rst_n = 1'b0;
        #1;
        chk("rst_valid", 32'(vld), 32'd0);
        chk("rst_busy",  32'(bsy), 32'd0);
        chk("rst_data0", dat[0], 32'd0);
        chk("rst_drop0", 32'(drop[0]), 32'd0);
        chk("rst_addr0", {19'd0, raddr[0], maddr[0]}, 32'd0);
        #1 rst_n = 1'b1;
        tick();

        // Basic dump with ready held high, busy length
        push_dump(0, 32'h10, 4, 0, 2);
        fire(0, 32'h10);
        run(0, 0, 1'b0, n);
        chk("busy_len", 32'(n), 32'd14);
        chk("q_empty1", 32'(q.size()), 32'd0);

        // Same dump with ready toggling
        push_dump(0, 32'h14, 4, 0, 2);
        fire(0, 32'h14);
        run(0, 1, 1'b0, n);
        chk("q_empty2", 32'(q.size()), 32'd0);

        // Triggers during a dump and on the END handshake are dropped
        push_dump(0, 32'h30, 4, 0, 2);
        fire(0, 32'h30);
        run(0, 0, 1'b1, n);
        repeat (4) tick();
        chk("drop_cnt", 32'(drop[0]), 32'd2);
        chk("no_extra_dump", 32'(bsy[0]), 32'd0);
        chk("q_empty3", 32'(q.size()), 32'd0);

        // PC-change mode
        push_dump(1, 32'h20, 4, 0, 2);
        fire(1, 32'h20);
        run(1, 0, 1'b0, n);
        fire(1, 32'h20);
        chk("mode1_same_pc", 32'(bsy[1]), 32'd0);
        repeat (3) tick();
        push_dump(1, 32'h24, 4, 0, 2);
        fire(1, 32'h24);
        run(1, 0, 1'b0, n);
        chk("mode1_drop", 32'(drop[1]), 32'd0);
        chk("q_empty4", 32'(q.size()), 32'd0);

        // Memory address wrap
        push_dump(2, 32'h50, 2, 254, 4);
        fire(2, 32'h50);
        run(2, 0, 1'b0, n);
        chk("memaddr_cnt", 32'(mk), 32'd4);
        chk("q_empty5", 32'(q.size()), 32'd0);

        // Asynchronous reset while a register word is stalled
        q.push_back({2'd0, 2'd0, 8'd0, 32'h40});
        fire(0, 32'h40);
        tick();
        rdy[0] = 1'b0;
        tick();
        tick();
        chk("stall_valid", 32'(vld[0]), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_valid", 32'(vld[0]), 32'd0);
        chk("arst_busy",  32'(bsy[0]), 32'd0);
        chk("arst_drop",  32'(drop[0]), 32'd0);
        #3 rst_n = 1'b1;
        rdy[0] = 1'b1;
        tick();
        chk("q_empty6", 32'(q.size()), 32'd0);
        push_dump(0, 32'h44, 4, 0, 2);
        fire(0, 32'h44);
        run(0, 0, 1'b0, n);
        chk("busy_len2", 32'(n), 32'd14);
        chk("q_empty7", 32'(q.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
